// File: rtl/fadd_accum_pkg.sv
// rtl/fadd_accum_pkg.sv - shared types and constants for the packet float accumulator
package fadd_accum_pkg;

   localparam logic [31:0] FP_ZERO = 32'h00000000;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   typedef struct packed {
      logic        last;
      logic [31:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/fadd.sv
// rtl/fadd.sv - combinational IEEE-754 single adder, round-to-nearest-even
module fadd (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res,
   output logic        ovf
);

   logic        a_nan, b_nan, a_inf, b_inf, a_big;
   logic [7:0]  ea, eb;
   logic [23:0] ma, mb;
   logic        sl, ss;
   logic [7:0]  el, es, d;
   logic [23:0] ml, ms;
   logic [4:0]  dc;
   logic [53:0] wide;
   logic [26:0] al, n;
   logic [27:0] s;
   logic [9:0]  lz, sh, el_w, e, en, ef;
   logic        rup;
   logic [24:0] m;
   logic [22:0] fr;

   // Denormals use exponent 1 with no hidden bit so alignment is uniform.
   assign ea    = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
   assign eb    = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
   assign ma    = {a[30:23] != 8'd0, a[22:0]};
   assign mb    = {b[30:23] != 8'd0, b[22:0]};
   assign a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
   assign b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
   assign a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
   assign b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
   assign a_big = {ea, ma} >= {eb, mb};

   // Align, add/subtract with guard/round/sticky, normalise, round, pack.
   always_comb begin
      res  = 32'd0;
      ovf  = 1'b0;
      sl   = a_big ? a[31] : b[31];
      ss   = a_big ? b[31] : a[31];
      el   = a_big ? ea : eb;
      es   = a_big ? eb : ea;
      ml   = a_big ? ma : mb;
      ms   = a_big ? mb : ma;
      d    = el - es;
      dc   = (d > 8'd27) ? 5'd27 : d[4:0];
      wide = {ms, 3'b000, 27'd0} >> dc;
      al   = {wide[53:28], wide[27] | (|wide[26:0])};
      if (sl == ss)
         s = {1'b0, ml, 3'b000} + {1'b0, al};
      else
         s = {1'b0, ml, 3'b000} - {1'b0, al};
      lz = 10'd0;
      for (int i = 0; i < 27; i++)
         if (s[i]) lz = 10'(26 - i);
      el_w = {2'b00, el};
      sh   = 10'd0;
      if (s[27]) begin
         n = {s[27:2], s[1] | s[0]};
         e = el_w + 10'd1;
      end else begin
         sh = (lz > el_w - 10'd1) ? el_w - 10'd1 : lz;
         n  = s[26:0] << sh;
         e  = el_w - sh;
      end
      en  = n[26] ? e : 10'd0;
      rup = n[2] & (n[1] | n[0] | n[3]);
      m   = {1'b0, n[26:3]} + {24'd0, rup};
      if (m[24]) begin
         ef = en + 10'd1;
         fr = 23'd0;
      end else if (en == 10'd0 && m[23]) begin
         ef = 10'd1;
         fr = m[22:0];
      end else begin
         ef = en;
         fr = m[22:0];
      end
      if (ef >= 10'd255) begin
         res = {sl, 8'hFF, 23'd0};
         ovf = 1'b1;
      end else begin
         res = {sl, ef[7:0], fr};
      end
      if (s == 28'd0) res = 32'd0;
      if (a_nan || b_nan) begin
         res = 32'h7FC00000;
         ovf = 1'b0;
      end else if (a_inf && b_inf) begin
         res = (a[31] != b[31]) ? 32'h7FC00000 : a;
         ovf = 1'b0;
      end else if (a_inf) begin
         res = a;
         ovf = 1'b0;
      end else if (b_inf) begin
         res = b;
         ovf = 1'b0;
      end
   end

endmodule

// File: rtl/fadd_accum_fifo.sv
// rtl/fadd_accum_fifo.sv - synchronous operand FIFO with wrap-bit pointers
module fadd_accum_fifo
   import fadd_accum_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  fifo_entry_t wdata,
   output fifo_entry_t rdata,
   output logic        full,
   output logic        empty
);

   localparam int AW = $clog2(DEPTH);

   fifo_entry_t    mem [DEPTH];
   logic [AW:0]    wptr, rptr;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full) begin
            mem[wptr[AW-1:0]] <= wdata;
            wptr              <= wptr + (AW+1)'(1);
         end
         if (pop && !empty)
            rptr <= rptr + (AW+1)'(1);
      end
   end

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/fadd_accum.sv
// rtl/fadd_accum.sv - serial packet accumulator of single-precision floats
module fadd_accum
   import fadd_accum_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_sum,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   state_t           state, state_nxt;
   logic [31:0]      acc;
   logic             ovf;
   logic [CNT_W-1:0] count;
   fifo_entry_t      head, wentry;
   logic             full, empty, push, pop;
   logic [31:0]      add_res;
   logic             add_ovf;

   assign wentry   = '{last: in_last, data: in_data};
   assign push     = in_valid && !full;
   assign pop      = (state == ACCUM) && !empty;
   assign in_ready = !full;

   fadd_accum_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (wentry),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   fadd u_fadd (
      .a   (acc),
      .b   (head.data),
      .res (add_res),
      .ovf (add_ovf)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ACCUM;
      else     state <= state_nxt;
   end

   // Leave ACCUM on popping a last element; leave DONE when the sum is taken.
   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (pop && head.last) state_nxt = DONE;
         DONE:    if (out_ready)        state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   // Accumulate one popped element per cycle; clear once the sum is handed off.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= FP_ZERO;
         ovf   <= 1'b0;
         count <= '0;
      end else if (pop) begin
         acc   <= add_res;
         ovf   <= ovf | add_ovf;
         count <= (&count) ? count : count + CNT_W'(1);
      end else if (state == DONE && out_ready) begin
         acc   <= FP_ZERO;
         ovf   <= 1'b0;
         count <= '0;
      end
   end

   assign out_valid = (state == DONE);
   assign out_sum   = acc;
   assign out_ovf   = ovf;
   assign out_count = count;

endmodule

// File: tb/tb_fadd_accum.sv
// tb/tb_fadd_accum.sv - randomized self-checking bench for fadd_accum
module tb_fadd_accum;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_last;
   logic [31:0]   in_data;
   logic          out_valid, out_ready, out_ovf;
   logic [31:0]   out_sum;
   logic [CW-1:0] out_count;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] sum;
      logic        ovf;
      int          cnt;
   } exp_t;

   exp_t        exp_q[$];
   real         part_sum = 0.0;
   int          part_cnt = 0;
   bit          part_ovf = 0;
   bit          rand_rdy = 0;
   logic        rdy_val  = 1'b1;
   int          vcount   = 0;
   bit          held     = 0;
   logic [31:0] prev_sum;
   logic        prev_ovf;
   logic [CW-1:0] prev_cnt;

   fadd_accum #(.FIFO_DEPTH(4), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic real pow2(input int k);
      real r = 1.0;
      if (k >= 0) repeat (k) r = r * 2.0;
      else        repeat (-k) r = r / 2.0;
      return r;
   endfunction

   function automatic real f2r(input logic [31:0] f);
      int  e = int'(f[30:23]);
      real v;
      if (e == 0) v = real'(int'(f[22:0])) * pow2(-149);
      else        v = (1.0 + real'(int'(f[22:0])) / 8388608.0) * pow2(e - 127);
      return f[31] ? -v : v;
   endfunction

   function automatic logic [31:0] r2f(input real x);
      logic s = (x < 0.0);
      real  a = s ? -x : x;
      int   e = 0;
      int   fr;
      if (a == 0.0) return 32'h0;
      if (a >= pow2(128)) return {s, 8'hFF, 23'h0};
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      fr = $rtoi((a - 1.0) * 8388608.0);
      return {s, 8'(e + 127), 23'(fr)};
   endfunction

   // Reference model: accepted operands form packets; expected sums queue in order.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         part_sum = 0.0;
         part_cnt = 0;
         part_ovf = 0;
         held     = 0;
      end else begin
         if (in_valid && in_ready) begin
            part_sum += f2r(in_data);
            part_cnt++;
            if (part_sum >= pow2(128) || part_sum <= -pow2(128)) part_ovf = 1;
            if (in_last) begin
               exp_q.push_back('{sum: r2f(part_sum), ovf: part_ovf,
                                 cnt: (part_cnt > 15) ? 15 : part_cnt});
               part_sum = 0.0;
               part_cnt = 0;
               part_ovf = 0;
            end
         end
         if (out_valid) vcount++;
         if (held) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", out_sum, prev_sum);
            check("hold_cnt", 32'(out_count), 32'(prev_cnt));
            check("hold_ovf", 32'(out_ovf), 32'(prev_ovf));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               check("sum", out_sum, exp_q[0].sum);
               check("ovf", 32'(out_ovf), 32'(exp_q[0].ovf));
               check("count", 32'(out_count), 32'(exp_q[0].cnt));
               void'(exp_q.pop_front());
            end
         end
         held     = out_valid && !out_ready;
         prev_sum = out_sum;
         prev_ovf = out_ovf;
         prev_cnt = out_count;
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
      end
   end

   task automatic send(input logic [31:0] d, input logic l);
      int n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = d; in_last = l;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 300) begin check("send_timeout", 32'd0, 32'd1); break; end
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 1000) begin @(negedge clk); n++; end
      if (n >= 1000) check("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", out_sum, 32'd0);
      check("rst_ovf", 32'(out_ovf), 32'd0);
      check("rst_count", 32'(out_count), 32'd0);
      @(posedge clk); #1; rst = 1'b0;

      // 1 + 2 + 0.5
      vcount = 0;
      send(32'h3F800000, 0); send(32'h40000000, 0); send(32'h3F000000, 1); idle();
      drain();
      check("t033_pulses", 32'(vcount), 32'd1);
      check("t033_model", r2f(3.5), 32'h40600000);

      // single element, latency
      send(32'h40490FDB, 1); idle();
      @(negedge clk); check("lat_t1", 32'(out_valid), 32'd0);
      @(negedge clk); check("lat_t2", 32'(out_valid), 32'd1);
      check("lat_sum", out_sum, 32'h40490FDB);
      drain();

      // cancellation
      send(32'h3F800000, 0); send(32'hBF800000, 1); idle();
      drain();

      // backpressure: FIFO fills while the sum is held
      rdy_val = 1'b0;
      send(32'h3F800000, 0); send(32'h40000000, 0); send(32'h40400000, 1);
      for (int i = 0; i < 4; i++) send(r2f(real'(i + 1)), 0);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 32'h40A00000; in_last = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("full_ready", 32'(in_ready), 32'd0);
      end
      check("held_valid", 32'(out_valid), 32'd1);
      check("held_sum", out_sum, 32'h40C00000);
      rdy_val = 1'b1;
      begin
         int n = 0;
         while (!in_ready && n < 50) begin @(negedge clk); n++; end
         check("release_ready", 32'(in_ready), 32'd1);
      end
      idle();
      drain();

      // reset mid-packet
      send(32'h41000000, 0); send(32'h41000000, 0);
      @(posedge clk); #1; in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sum", out_sum, 32'd0);
      check("mid_rst_count", 32'(out_count), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      send(32'h40000000, 1); idle();
      drain();

      // overflow, then confirm the flag clears for the next packet
      send(32'h7F7FFFFF, 0); send(32'h7F7FFFFF, 1); send(32'h3F800000, 1); idle();
      drain();

      // random back-to-back packets with random downstream stalls
      rand_rdy = 1;
      for (int p = 0; p < 40; p++) begin
         int len = ($urandom_range(0, 4) == 0) ? 1 : int'($urandom_range(1, 18));
         for (int k = 0; k < len; k++) begin
            int v = int'($urandom_range(0, 128)) - 64;
            send(r2f(real'(v) / 4.0), k == len - 1);
         end
      end
      idle();
      rand_rdy = 0;
      rdy_val  = 1'b1;
      drain();
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fadd_accum.md
FADD_ACCUM -- requirements
Module: fadd_accum

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, input operand FIFO entries (power of two, >=2).
REQ-002 Parameter CNT_W, default 16, width of element counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream operand present.
REQ-006 in_ready  output  1  operand accepted when in_valid && in_ready.
REQ-007 in_data  input  32  IEEE-754 single operand.
REQ-008 in_last  input  1  operand is final element of current packet.
REQ-009 out_valid  output  1  packet sum available.
REQ-010 out_ready  input  1  downstream takes sum when out_valid && out_ready.
REQ-011 out_sum  output  32  accumulated single-precision sum.
REQ-012 out_ovf  output  1  sticky OR of fadd ovf over the packet.
REQ-013 out_count  output  CNT_W  elements summed in packet, saturating.

Function
REQ-014 Block SHALL sum a packet of floats serially through one instance of the existing combinational fadd (a = accumulator, b = FIFO head).
REQ-015 Each accepted {in_last, in_data} SHALL be written into a FIFO_DEPTH-entry FIFO; in_ready = FIFO not full.
REQ-016 Push and pop in the same cycle SHALL be legal whenever FIFO is non-full; push when full SHALL never occur.
REQ-017 States: ACCUM, DONE.
REQ-018 ACCUM: if FIFO non-empty, pop head; acc <= fadd.res; ovf <= ovf | fadd.ovf; count <= count+1 saturating at all-ones; one element per cycle.
REQ-019 ACCUM: if popped entry has last=1, next state DONE.
REQ-020 DONE: out_valid=1; acc, ovf, count held; no pops; FIFO still accepts pushes.
REQ-021 DONE with out_ready=1: acc <= 32'h00000000, ovf <= 0, count <= 0, next state ACCUM.
REQ-022 out_sum, out_ovf, out_count SHALL be driven directly from registers; stable while out_valid && !out_ready.
REQ-023 Latency: operand pushed in cycle t is earliest popped in cycle t+1; out_valid rises the cycle after the last element is popped.
REQ-024 Empty FIFO in ACCUM SHALL leave all state unchanged.
REQ-025 Every packet SHALL contain >=1 element; block SHALL not emit a sum without a popped last.
REQ-026 NaN/Inf handling SHALL be that of fadd; block SHALL add no special-casing.

Reset
REQ-027 rst=1 SHALL, on the next edge, empty the FIFO, set state ACCUM, acc=0, ovf=0, count=0.
REQ-028 During and after reset: in_ready=1 (after first edge), out_valid=0, out_sum=0, out_ovf=0, out_count=0.
REQ-029 Reset mid-packet or in DONE SHALL discard the partial/pending sum and all FIFO contents.

Structure
REQ-030 Package fadd_accum_pkg SHALL hold FP_ZERO (32'h00000000), state enum, and FIFO entry struct {last, data[31:0]}.
REQ-031 FIFO SHALL be a sub-module fadd_accum_fifo (sync, registered, full/empty flags, pointer wrap with extra MSB).
REQ-032 fadd SHALL be instantiated unchanged; no retiming of its logic.

Verification
REQ-033 Push 3F800000, 40000000, 3F000000(last), out_ready=1 -> out_sum=40600000, out_count=3, out_ovf=0, one out_valid pulse.
REQ-034 Single element 40490FDB(last) -> out_sum=40490FDB, out_count=1, out_valid in cycle t+2 after push.
REQ-035 Push 3F800000, BF800000(last) -> out_sum=00000000, out_count=2.
REQ-036 out_ready=0 for 12 cycles after first packet, stream 5 more operands -> in_ready=0 after 4 accepted, out_sum unchanged, no operand lost when released.
REQ-037 Assert rst after 2 of 4 elements -> out_valid=0, FIFO empty; next packet 40000000(last) -> out_sum=40000000, out_count=1.
REQ-038 Back-to-back packets with in_valid held high -> sums independent, counts correct, no cycle with pop in DONE.
